// File: rtl/obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : obi_mem_responder
// Brief    : OBI responder data memory, 64-bit byte-masked words, fixed
//            LATENCY response pipeline. Define OBI_RESP_STALL_EN for
//            LFSR-driven random wait states on gnt_o.
// Revision : 1.0 - initial release
// ============================================================================
module obi_mem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [63:0] addr_i,
    input  logic        we_i,
    input  logic [7:0]  be_i,
    input  logic [63:0] wdata_i,
    output logic        rvalid_o,
    output logic [63:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] c_SPAN  = 64'(DEPTH) << 3;

    logic [63:0]        w_offset;
    logic [c_IDX_W-1:0] w_index;
    logic               w_in_range;
    logic               w_accept;
    logic [63:0]        w_rd_data;

    logic [63:0]              r_mem [DEPTH];
    logic [LATENCY-1:0]       r_valid;
    logic [LATENCY-1:0]       r_err;
    logic [LATENCY-1:0][63:0] r_data;

    assign w_offset   = addr_i - BASE_ADDR;
    assign w_index    = w_offset[3 +: c_IDX_W];
    assign w_in_range = (addr_i >= BASE_ADDR) && (w_offset < c_SPAN);

`ifdef OBI_RESP_STALL_EN
    // Fibonacci LFSR, taps 16,14,13,11; bit 0 withholds the grant
    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    assign gnt_o = req_i & ~r_lfsr[0];
`else
    assign gnt_o = req_i;
`endif

    assign w_accept = req_i & gnt_o;

    // Contents survive reset on purpose: accepted writes must persist
    always_ff @(posedge clk_i) begin
        if (w_accept && we_i && w_in_range) begin
            for (int b = 0; b < 8; b++) begin
                if (be_i[b]) begin
                    r_mem[w_index][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign w_rd_data = (w_accept && !we_i && w_in_range) ? r_mem[w_index] : 64'h0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            r_err   <= '0;
            r_data  <= '0;
        end else begin
            r_valid[0] <= w_accept;
            r_err[0]   <= w_accept & ~w_in_range;
            r_data[0]  <= w_rd_data;
            for (int s = 1; s < int'(LATENCY); s++) begin
                r_valid[s] <= r_valid[s-1];
                r_err[s]   <= r_err[s-1];
                r_data[s]  <= r_data[s-1];
            end
        end
    end

    assign rvalid_o = r_valid[LATENCY-1];
    assign err_o    = r_err[LATENCY-1];
    assign rdata_o  = r_data[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_mem_responder
// Brief    : Directed vector table plus random traffic against LATENCY=1 and
//            LATENCY=3 instances sharing one request stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obi_mem_responder;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [63:0] addr  = 64'h0;
    logic [7:0]  be    = 8'h0;
    logic [63:0] wdata = 64'h0;

    logic        gnt1, gnt3, rv1, rv3, er1, er3;
    logic [63:0] rd1, rd3;

    always #5 clk = ~clk;

    obi_mem_responder #(.DEPTH(1024), .LATENCY(1), .BASE_ADDR(64'h0)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt1), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rv1), .rdata_o(rd1), .err_o(er1)
    );

    obi_mem_responder #(.DEPTH(1024), .LATENCY(3), .BASE_ADDR(64'h0)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt3), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rv3), .rdata_o(rd3), .err_o(er3)
    );

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    exp_t        q1[$];
    exp_t        q3[$];
    vec_t        tbl[18];
    logic [63:0] mdl[16];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Every response must match the oldest outstanding grant, at exact latency
    task automatic mon(input int lat, input logic v, input logic [63:0] d, input logic e);
        exp_t x;
        if (v === 1'b1) begin
            if ((lat == 1) ? (q1.size() == 0) : (q3.size() == 0)) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rvalid L%0d: got rvalid 1 expected 0 (t=%0t)", lat, $time);
            end else begin
                x = (lat == 1) ? q1.pop_front() : q3.pop_front();
                chk($sformatf("rdata_L%0d", lat), d, x.data);
                chk($sformatf("err_L%0d", lat), {63'h0, e}, {63'h0, x.err});
                chk($sformatf("latency_L%0d", lat), 64'(cyc - x.cyc), 64'(lat - 1));
            end
        end else begin
            chk($sformatf("idle_rvalid_L%0d", lat), {63'h0, v}, 64'h0);
            chk($sformatf("idle_rdata_L%0d", lat), d, 64'h0);
            chk($sformatf("idle_err_L%0d", lat), {63'h0, e}, 64'h0);
        end
    endtask

    always @(posedge clk) begin
        #2;
        mon(1, rv1, rd1, er1);
        mon(3, rv3, rd3, er3);
    end

    // Called at posedge+1; holds the request until granted
    task automatic issue(input logic w, input logic [63:0] a, input logic [7:0] b,
                         input logic [63:0] wd, input logic [63:0] ed, input logic ee);
        logic g;
        int   n;
        exp_t x;
        req = 1'b1; we = w; addr = a; be = b; wdata = wd;
        g = 1'b0;
        n = 0;
        while (!g && n < 64) begin
            @(negedge clk);
            g = gnt1;
            chk("gnt_L3_vs_L1", {63'h0, gnt3}, {63'h0, gnt1});
`ifndef OBI_RESP_STALL_EN
            chk("gnt_same_cycle", {63'h0, g}, 64'h1);
`endif
            @(posedge clk);
            #1;
            n++;
        end
        if (!g) begin
            n_cmp++;
            n_fail++;
            $display("FAIL grant_timeout: got no grant expected grant for addr %h", a);
        end else begin
            x.data = ed;
            x.err  = ee;
            x.cyc  = cyc;
            q1.push_back(x);
            q3.push_back(x);
        end
        req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1);
    end

    initial begin
        logic [63:0] a, wd, m;
        logic [7:0]  b;
        int          op, idx;

        tbl[0]  = '{1'b1, 64'h10,   8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0};
        tbl[1]  = '{1'b0, 64'h10,   8'hFF, 64'h0,                   64'h0123_4567_89AB_CDEF, 1'b0};
        tbl[2]  = '{1'b1, 64'h10,   8'h04, {8{8'h5A}},              64'h0, 1'b0};
        tbl[3]  = '{1'b0, 64'h10,   8'hFF, 64'h0,                   64'h0123_4567_895A_CDEF, 1'b0};
        tbl[4]  = '{1'b1, 64'h10,   8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0};
        tbl[5]  = '{1'b0, 64'h10,   8'hFF, 64'h0,                   64'h0123_4567_895A_CDEF, 1'b0};
        tbl[6]  = '{1'b1, 64'h0,    8'hFF, 64'h1,                   64'h0, 1'b0};
        tbl[7]  = '{1'b0, 64'h2000, 8'hFF, 64'h0,                   64'h0, 1'b1};
        tbl[8]  = '{1'b1, 64'h2000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0, 1'b1};
        tbl[9]  = '{1'b0, 64'h0,    8'hFF, 64'h0,                   64'h1, 1'b0};
        tbl[10] = '{1'b1, 64'h8,    8'hFF, 64'h2,                   64'h0, 1'b0};
        tbl[11] = '{1'b1, 64'h10,   8'hFF, 64'h3,                   64'h0, 1'b0};
        tbl[12] = '{1'b1, 64'h18,   8'hFF, 64'h4,                   64'h0, 1'b0};
        tbl[13] = '{1'b0, 64'h0,    8'hFF, 64'h0,                   64'h1, 1'b0};
        tbl[14] = '{1'b0, 64'h8,    8'hFF, 64'h0,                   64'h2, 1'b0};
        tbl[15] = '{1'b0, 64'h10,   8'hFF, 64'h0,                   64'h3, 1'b0};
        tbl[16] = '{1'b0, 64'h18,   8'hFF, 64'h0,                   64'h4, 1'b0};
        tbl[17] = '{1'b0, 64'h1F,   8'hFF, 64'h0,                   64'h4, 1'b0};

        // Reset for 3 cycles, then 10 idle cycles
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_gnt", {63'h0, gnt1}, 64'h0);
            @(posedge clk);
            #1;
        end

        foreach (tbl[i])
            issue(tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata, tbl[i].exp_data, tbl[i].exp_err);
        repeat (4) @(posedge clk);
        #1;

        // Reset one cycle after granting a read: L3 response must vanish
        issue(1'b0, 64'h8, 8'hFF, 64'h0, 64'h2, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q3.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        issue(1'b0, 64'h8,  8'hFF, 64'h0, 64'h2, 1'b0);
        issue(1'b0, 64'h10, 8'hFF, 64'h0, 64'h3, 1'b0);

        // Random traffic against a 16-word reference model at 0x100
        for (int i = 0; i < 16; i++) begin
            wd = {$urandom, $urandom};
            mdl[i] = wd;
            issue(1'b1, 64'h100 + 64'(i * 8), 8'hFF, wd, 64'h0, 1'b0);
        end
        for (int i = 0; i < 200; i++) begin
            op  = int'($urandom_range(0, 9));
            idx = int'($urandom_range(0, 15));
            a   = 64'h100 + 64'(idx * 8) + 64'($urandom_range(0, 7));
            b   = 8'($urandom);
            wd  = {$urandom, $urandom};
            if (op == 0) begin
                issue(op[0] ^ 1'($urandom), 64'h2000 + a, b, wd, 64'h0, 1'b1);
            end else if (op < 5) begin
                issue(1'b0, a, b, 64'h0, mdl[idx], 1'b0);
            end else begin
                m = mdl[idx];
                for (int k = 0; k < 8; k++)
                    if (b[k]) m[8*k +: 8] = wd[8*k +: 8];
                mdl[idx] = m;
                issue(1'b1, a, b, wd, 64'h0, 1'b0);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (8) @(posedge clk);
        #3;
        chk("drained_L1", 64'(q1.size()), 64'h0);
        chk("drained_L3", 64'(q3.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/obi_mem_responder.md
Name: obi_mem_responder

Overview:
- OBI device-side (responder) data memory for the core's data port; it is the other end of the memory stage's host driver.
- Accepts 64-bit doubleword requests with byte enables and performs synchronous reads and byte-masked writes to an internal array.
- Returns one response per accepted request after a fixed latency.
- Used as the simulation/FPGA data memory behind the dmem OBI bus.

Parameters:
- DEPTH, 1024, number of 64-bit words; power of 2, >= 2.
- LATENCY, 1, cycles from grant edge to rvalid_o; legal range 1..4.
- BASE_ADDR, 64'h0, byte address of word 0; must be DEPTH*8-aligned.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  host request valid.
- gnt_o  out  1  request accepted this cycle (combinational).
- addr_i  in  64  byte address; bits [2:0] ignored.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  8  byte enables; bit n controls byte lane n (wdata_i[8n+7:8n]).
- wdata_i  in  64  write data, already lane-replicated by the host.
- rvalid_o  out  1  response valid, exactly one cycle per accepted request.
- rdata_o  out  64  read data; 0 for write responses.
- err_o  out  1  response error (address out of range); valid with rvalid_o.

Behaviour:
- Reset (async assert, sync-released use): rvalid_o=0, rdata_o=0, err_o=0; all response-pipeline valid bits cleared. Memory contents are not reset.
- Acceptance: accept = req_i & gnt_o. Without the optional feature, gnt_o = req_i, so every request is accepted in the cycle it is presented. gnt_o is never asserted while req_i=0.
- Indexing: offset = addr_i - BASE_ADDR; index = offset[3 +: log2(DEPTH)]; in_range = (addr_i >= BASE_ADDR) && (offset < DEPTH*8).
- Write, on accept edge:
  - in_range: mem[index] byte n <= wdata_i byte n for each be_i[n]=1; all other bytes unchanged.
  - be_i=0: no bytes change, but a response is still issued.
  - out of range: no array change.
- Read, on accept edge: stage-1 data captured = mem[index] (pre-write value; a read and a write never share a cycle since only one request is accepted per cycle).
- Response pipeline: a LATENCY-deep shift register of {valid, err, data}.
  - Stage 1 is loaded on every edge: valid=accept; err=accept & ~in_range; data=(accept & ~we_i & in_range) ? mem[index] : 0.
  - The final stage drives rvalid_o/err_o/rdata_o directly.
  - Hence the response for a request granted at edge k appears in the cycle after edge k+LATENCY-1. LATENCY=1 means rvalid_o in the cycle immediately following the grant cycle.
- Ordering: responses are in request order. Back-to-back requests give back-to-back rvalid_o with no bubbles.
- Read-after-write: a read accepted any cycle after a write to the same word returns the written bytes merged with the unwritten bytes.
- Outputs when rvalid_o=0: rdata_o=0 and err_o=0.
- Reset mid-operation: in-flight responses are dropped, with no rvalid_o after reset deasserts. Writes already accepted remain in memory.
- No backpressure on responses. The host must always accept rvalid_o.

Optional Feature:
- Macro OBI_RESP_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - gnt_o = req_i & ~lfsr[0], injecting pseudo-random wait states so host stall paths get exercised.
  - A request held with gnt_o=0 is not accepted and has no side effect. The host must hold addr_i/we_i/be_i/wdata_i stable until granted.
  - Latency is still measured from the granting edge.
- Undefined: gnt_o = req_i; no LFSR logic is present.

Test Plan:
- Reset then idle: hold rst_ni=0 for 3 cycles, release, req_i=0 for 10 cycles -> rvalid_o=0, rdata_o=0, err_o=0 and gnt_o=0 throughout.
- Full-word write/read, LATENCY=1:
  - Write addr 0x10, be 8'hFF, wdata 64'h0123_4567_89AB_CDEF -> gnt_o=1 same cycle; next cycle rvalid_o=1, rdata_o=0, err_o=0.
  - Then read 0x10 -> next cycle rdata_o=64'h0123_4567_89AB_CDEF.
- Byte-masked merge:
  - After the prior write, write addr 0x10, be 8'b0000_0100, wdata {8{8'h5A}} -> a later read of 0x10 returns 64'h0123_4567_895A_CDEF.
  - Write with be 8'h00 -> data unchanged, rvalid_o still pulses once.
- Out-of-range, DEPTH=1024: read addr 0x2000 -> rvalid_o=1, err_o=1, rdata_o=0. Write to 0x2000 then read 0x0 -> word 0 unchanged.
- Pipelined throughput, LATENCY=3: 4 consecutive reads of 0x00, 0x08, 0x10, 0x18 (preloaded 1..4) -> rvalid_o high for 4 consecutive cycles starting 3 cycles after the first grant, with rdata_o 1, 2, 3, 4 in order.
- Reset mid-flight plus stall feature:
  - LATENCY=3: grant a read, assert rst_ni=0 one cycle later -> no rvalid_o ever appears for it.
  - With OBI_RESP_STALL_EN defined: 200 random requests -> every request gets exactly one response, in order, with data matching a reference model.
